ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline.
- Sits at the far end of the decode interface. It consumes the decoder's aluop/alusel/operand/destination bundle through an internal ID/EX pipeline register.
- Computes logic, shift and move results plus HI/LO writes.
- Drives ex_wreg_o/ex_wd_o/ex_wdata_o back to decode as the EX forwarding source, and forward into EX/MEM.

Parameters:
- DATA_W, 32, width of register and operand buses (RegBus)
- ADDR_W, 5, register address width (RegAddrBus)
- ALUOP_W, 8, aluop width (AluOpBus)
- ALUSEL_W, 3, alusel width (AluSelBus)

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset, synchronous, active-high (RstEnable)
- stall_i  in  1  hold ID/EX register contents
- flush_i  in  1  load a bubble into ID/EX register
- id_aluop_i  in  ALUOP_W  ALU operation from decode
- id_alusel_i  in  ALUSEL_W  result class from decode (NOP/LOGIC/SHIFT/MOVE)
- id_reg1_i  in  DATA_W  operand 1 (rs, or shift amount for SLL/SRL/SRA)
- id_reg2_i  in  DATA_W  operand 2 (rt or immediate)
- id_wd_i  in  ADDR_W  destination register
- id_wreg_i  in  1  destination write enable
- hi_i, lo_i  in  DATA_W each  architectural HI/LO
- mem_whilo_i  in  1  MEM-stage HI/LO write pending
- mem_hi_i, mem_lo_i  in  DATA_W each  MEM-stage HI/LO values
- wb_whilo_i  in  1  WB-stage HI/LO write pending
- wb_hi_i, wb_lo_i  in  DATA_W each  WB-stage HI/LO values
- ex_wreg_o  out  1  result write enable
- ex_wd_o  out  ADDR_W  result destination
- ex_wdata_o  out  DATA_W  result data
- ex_whilo_o  out  1  HI/LO write enable
- ex_hi_o, ex_lo_o  out  DATA_W each  HI/LO write values

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high: on a posedge with rst=1, the ID/EX register loads NOP.
  - NOP state: aluop=EXE_NOP_OP, alusel=EXE_RES_NOP, reg1=0, reg2=0, wd=0, wreg=0.
  - All outputs are then 0.
- ID/EX register update on each posedge with rst=0, priority flush > stall > load:
  - flush_i=1: load NOP.
  - stall_i=1: hold contents.
  - otherwise: capture the id_* inputs.
- Latency: outputs are combinational from the captured state. An instruction presented at decode appears on ex_* in the cycle after the capture edge.
- Output routing:
  - ex_wd_o = captured wd.
  - ex_wreg_o = captured wreg; MOVN/MOVZ are the exception, see Optional Feature.
- LOGIC results:
  - AND/ANDI = r1 & r2.
  - OR/ORI/LUI = r1 | r2.
  - XOR/XORI = r1 ^ r2.
  - NOR = ~(r1 | r2).
- SHIFT results, shift amount always r1[4:0]:
  - SLL/SLLV = r2 << r1[4:0].
  - SRL/SRLV = logical right shift of r2.
  - SRA/SRAV = arithmetic right shift of r2; r2[31] replicates.
  - Shift amount 0 returns r2 unchanged.
- HI/LO forwarding: per-field source priority is MEM > WB > architectural.
  - hi_fwd = mem_hi_i if mem_whilo_i, else wb_hi_i if wb_whilo_i, else hi_i.
  - lo_fwd is selected the same way.
- MOVE results:
  - MFHI = hi_fwd.
  - MFLO = lo_fwd.
  - MOVN/MOVZ = r1.
- Result select: ex_wdata_o is taken from the class given by the captured alusel. Unknown alusel or aluop gives ex_wdata_o=0.
- MTHI: ex_whilo_o=1, ex_hi_o=r1, ex_lo_o=lo_fwd.
- MTLO: ex_whilo_o=1, ex_hi_o=hi_fwd, ex_lo_o=r1.
- All other ops: ex_whilo_o=0, ex_hi_o=0, ex_lo_o=0.
- Simultaneous stall and flush: flush wins.
- Reset asserted mid-stall: reset wins; NOP state next cycle.
- Bubble semantics: a bubble must never assert ex_wreg_o or ex_whilo_o.

Optional Feature:
- Macro: EX_MOVCOND_EN.
- Defined: for MOVN, ex_wreg_o = captured wreg AND (r2 != 0). For MOVZ, ex_wreg_o = captured wreg AND (r2 == 0). The condition is evaluated on the fully forwarded operand captured in ID/EX.
- Undefined: ex_wreg_o passes captured wreg unchanged for MOVN/MOVZ; decode is then responsible for the condition.

Decomposition:
- Shared package/defines (already common with decode):
  - aluop codes, alusel codes
  - RstEnable
  - WriteEnable/WriteDisable
  - RegBus/RegAddrBus/AluOpBus/AluSelBus widths
  - NOP register address
- One natural sub-module: ex_shifter. It is combinational, taking a 32-bit operand, a 5-bit amount and a 2-bit mode (SLL/SRL/SRA).
- The ID/EX register and the result mux stay in ex_stage.

Test Plan:
- Reset and pipeline:
  - rst=1 for 2 cycles, then an OR bundle r1=0x0F0F0000, r2=0x000000FF, wd=5, wreg=1 → ex_wreg_o=0 during reset.
  - Cycle after capture: ex_wdata_o=0x0F0F00FF, ex_wd_o=5, ex_wreg_o=1.
- Shifts:
  - SRA r1=4, r2=0x80000010 → 0xF8000001.
  - SRL same operands → 0x08000001.
  - SLLV r1=0x00000021, r2=1 → 0x00000002 (amount uses bits [4:0] only).
- HI/LO priority, with hi_i=0x11, wb_hi=0x22 (wb_whilo=1), mem_hi=0x33:
  - mem_whilo=1 → MFHI gives 0x33.
  - mem_whilo=0 → MFHI gives 0x22.
  - MTLO r1=0xABCD → ex_whilo_o=1, ex_lo_o=0xABCD, ex_hi_o=forwarded HI.
- Stall/flush:
  - Capture XOR, then hold stall_i=1 for 3 cycles while the id_* inputs change → ex_* outputs stay constant.
  - Assert stall and flush together → next cycle ex_wreg_o=0, ex_wdata_o=0.
- MOVZ/MOVN under EX_MOVCOND_EN: wreg=1, r1=0x55.
  - MOVZ with r2=0 → ex_wreg_o=1, data 0x55.
  - MOVZ with r2=7 → ex_wreg_o=0.
  - MOVN with r2=7 → ex_wreg_o=1.
  - Without the macro, ex_wreg_o=1 in all three.
- Reset mid-stall: stall_i=1 holding AND, assert rst for one cycle → all outputs 0 next cycle, and a new bundle is captured afterwards.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// Shared execute-stage definitions: aluop/alusel codes, control levels, bus widths.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: bus widths (RegBus/RegAddrBus/AluOpBus/AluSelBus), reset and
// write-enable levels, NOP register address, aluop and alusel encodings
// common with decode, the shifter mode type and the aluop-to-shift-mode
// helper.
package ex_stage_pkg;

  // Bus widths shared with decode
  localparam int REG_BUS_W      = 32;  // RegBus
  localparam int REG_ADDR_BUS_W = 5;   // RegAddrBus
  localparam int ALUOP_BUS_W    = 8;   // AluOpBus
  localparam int ALUSEL_BUS_W   = 3;   // AluSelBus

  // Control levels
  localparam logic RST_ENABLE    = 1'b1;
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;

  localparam logic [4:0] NOP_REG_ADDR = 5'd0;

  // aluop codes
  localparam logic [7:0] EXE_NOP_OP  = 8'b0000_0000;
  localparam logic [7:0] EXE_AND_OP  = 8'b0010_0100;
  localparam logic [7:0] EXE_OR_OP   = 8'b0010_0101;
  localparam logic [7:0] EXE_XOR_OP  = 8'b0010_0110;
  localparam logic [7:0] EXE_NOR_OP  = 8'b0010_0111;
  localparam logic [7:0] EXE_ANDI_OP = 8'b0101_1001;
  localparam logic [7:0] EXE_ORI_OP  = 8'b0101_1010;
  localparam logic [7:0] EXE_XORI_OP = 8'b0101_1011;
  localparam logic [7:0] EXE_LUI_OP  = 8'b0101_1100;
  localparam logic [7:0] EXE_SLL_OP  = 8'b0111_1100;
  localparam logic [7:0] EXE_SLLV_OP = 8'b0000_0100;
  localparam logic [7:0] EXE_SRL_OP  = 8'b0000_0010;
  localparam logic [7:0] EXE_SRLV_OP = 8'b0000_0110;
  localparam logic [7:0] EXE_SRA_OP  = 8'b0000_0011;
  localparam logic [7:0] EXE_SRAV_OP = 8'b0000_0111;
  localparam logic [7:0] EXE_MOVZ_OP = 8'b0000_1010;
  localparam logic [7:0] EXE_MOVN_OP = 8'b0000_1011;
  localparam logic [7:0] EXE_MFHI_OP = 8'b0001_0000;
  localparam logic [7:0] EXE_MTHI_OP = 8'b0001_0001;
  localparam logic [7:0] EXE_MFLO_OP = 8'b0001_0010;
  localparam logic [7:0] EXE_MTLO_OP = 8'b0001_0011;

  // alusel (result class) codes
  localparam logic [2:0] EXE_RES_NOP   = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [2:0] EXE_RES_MOVE  = 3'b011;

  // Shifter mode; SH_NONE makes the shifter output 0 so a non-shift aluop
  // under the SHIFT class yields a zero result.
  typedef enum logic [1:0] {
    SH_SLL  = 2'd0,
    SH_SRL  = 2'd1,
    SH_SRA  = 2'd2,
    SH_NONE = 2'd3
  } shift_mode_e;

  // Immediate and variable forms share a mode: amount always comes from reg1.
  function automatic shift_mode_e shift_mode_of(input logic [7:0] aluop);
    shift_mode_e m;
    m = SH_NONE;
    case (aluop)
      EXE_SLL_OP, EXE_SLLV_OP: m = SH_SLL;
      EXE_SRL_OP, EXE_SRLV_OP: m = SH_SRL;
      EXE_SRA_OP, EXE_SRAV_OP: m = SH_SRA;
      default:                 m = SH_NONE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ex_shifter.sv
// Barrel shifter for the execute stage: SLL, SRL and SRA on one operand.
// Latency: purely combinational.
// Backpressure: none (no state, no handshake).
//
// Ports:
//   i_dat  [DATA_W-1:0]  operand to shift (rt)
//   i_amt  [4:0]         shift amount; 0 returns i_dat unchanged
//   i_mode shift_mode_e  SH_SLL / SH_SRL / SH_SRA; SH_NONE gives 0
//   o_dat  [DATA_W-1:0]  shifted result
module ex_shifter
  import ex_stage_pkg::*;
#(
  parameter int DATA_W = REG_BUS_W
) (
  input  logic [DATA_W-1:0] i_dat,
  input  logic [4:0]        i_amt,
  input  shift_mode_e       i_mode,
  output logic [DATA_W-1:0] o_dat
);

  always_comb begin
    o_dat = '0;
    case (i_mode)
      SH_SLL:  o_dat = i_dat << i_amt;
      SH_SRL:  o_dat = i_dat >> i_amt;
      // Signed cast makes >>> replicate the sign bit.
      SH_SRA:  o_dat = DATA_W'($signed(i_dat) >>> i_amt);
      default: o_dat = '0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: ID/EX register, logic/shift/move results and HI/LO writes.
// Latency: one cycle from decode capture to ex_* (outputs combinational from ID/EX).
// Backpressure: stall_i holds ID/EX, flush_i loads a bubble (flush wins over stall).
//
// Build option: define EX_MOVCOND_EN to gate MOVN/MOVZ write enable on rt here;
// otherwise decode has already resolved the condition into id_wreg_i.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   stall_i, flush_i    ID/EX hold / bubble insert
//   id_aluop_i, id_alusel_i, id_reg1_i, id_reg2_i, id_wd_i, id_wreg_i
//                       decoded instruction bundle
//   hi_i, lo_i          architectural HI/LO
//   mem_whilo_i, mem_hi_i, mem_lo_i   MEM-stage HI/LO write in flight
//   wb_whilo_i,  wb_hi_i,  wb_lo_i    WB-stage HI/LO write in flight
//   ex_wreg_o, ex_wd_o, ex_wdata_o    GPR result (also EX forwarding source)
//   ex_whilo_o, ex_hi_o, ex_lo_o      HI/LO write
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int DATA_W   = REG_BUS_W,
  parameter int ADDR_W   = REG_ADDR_BUS_W,
  parameter int ALUOP_W  = ALUOP_BUS_W,
  parameter int ALUSEL_W = ALUSEL_BUS_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_i,
  input  logic                flush_i,
  input  logic [ALUOP_W-1:0]  id_aluop_i,
  input  logic [ALUSEL_W-1:0] id_alusel_i,
  input  logic [DATA_W-1:0]   id_reg1_i,
  input  logic [DATA_W-1:0]   id_reg2_i,
  input  logic [ADDR_W-1:0]   id_wd_i,
  input  logic                id_wreg_i,
  input  logic [DATA_W-1:0]   hi_i,
  input  logic [DATA_W-1:0]   lo_i,
  input  logic                mem_whilo_i,
  input  logic [DATA_W-1:0]   mem_hi_i,
  input  logic [DATA_W-1:0]   mem_lo_i,
  input  logic                wb_whilo_i,
  input  logic [DATA_W-1:0]   wb_hi_i,
  input  logic [DATA_W-1:0]   wb_lo_i,
  output logic                ex_wreg_o,
  output logic [ADDR_W-1:0]   ex_wd_o,
  output logic [DATA_W-1:0]   ex_wdata_o,
  output logic                ex_whilo_o,
  output logic [DATA_W-1:0]   ex_hi_o,
  output logic [DATA_W-1:0]   ex_lo_o
);

  // ---------------------------------------------------------------------------
  // ID/EX pipeline register
  // ---------------------------------------------------------------------------
  logic [ALUOP_W-1:0]  r_aluop;
  logic [ALUSEL_W-1:0] r_alusel;
  logic [DATA_W-1:0]   r_reg1;
  logic [DATA_W-1:0]   r_reg2;
  logic [ADDR_W-1:0]   r_wd;
  logic                r_wreg;

  // Priority reset > flush > stall > load. Reset and flush both leave a
  // bubble whose wreg is clear, so a bubble can never write anything.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE || flush_i) begin
      r_aluop  <= ALUOP_W'(EXE_NOP_OP);
      r_alusel <= ALUSEL_W'(EXE_RES_NOP);
      r_reg1   <= '0;
      r_reg2   <= '0;
      r_wd     <= ADDR_W'(NOP_REG_ADDR);
      r_wreg   <= WRITE_DISABLE;
    end else if (!stall_i) begin
      r_aluop  <= id_aluop_i;
      r_alusel <= id_alusel_i;
      r_reg1   <= id_reg1_i;
      r_reg2   <= id_reg2_i;
      r_wd     <= id_wd_i;
      r_wreg   <= id_wreg_i;
    end
  end

  // ---------------------------------------------------------------------------
  // HI/LO forwarding: the youngest pending write wins (MEM is younger than WB).
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] w_hi_fwd;
  logic [DATA_W-1:0] w_lo_fwd;

  always_comb begin
    if (mem_whilo_i) begin
      w_hi_fwd = mem_hi_i;
      w_lo_fwd = mem_lo_i;
    end else if (wb_whilo_i) begin
      w_hi_fwd = wb_hi_i;
      w_lo_fwd = wb_lo_i;
    end else begin
      w_hi_fwd = hi_i;
      w_lo_fwd = lo_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Logic class
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] w_logic_res;

  // LUI arrives with the immediate already in the upper half of reg2 and
  // reg1 = 0, so it shares the OR path.
  always_comb begin
    w_logic_res = '0;
    case (r_aluop)
      EXE_AND_OP, EXE_ANDI_OP:             w_logic_res = r_reg1 & r_reg2;
      EXE_OR_OP, EXE_ORI_OP, EXE_LUI_OP:   w_logic_res = r_reg1 | r_reg2;
      EXE_XOR_OP, EXE_XORI_OP:             w_logic_res = r_reg1 ^ r_reg2;
      EXE_NOR_OP:                          w_logic_res = ~(r_reg1 | r_reg2);
      default:                             w_logic_res = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Shift class; only reg1[4:0] is the amount, upper reg1 bits are ignored.
  // ---------------------------------------------------------------------------
  shift_mode_e       w_shift_mode;
  logic [DATA_W-1:0] w_shift_res;

  assign w_shift_mode = shift_mode_of(8'(r_aluop));

  ex_shifter #(
    .DATA_W (DATA_W)
  ) u_shifter (
    .i_dat  (r_reg2),
    .i_amt  (r_reg1[4:0]),
    .i_mode (w_shift_mode),
    .o_dat  (w_shift_res)
  );

  // ---------------------------------------------------------------------------
  // Move class
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] w_move_res;

  always_comb begin
    w_move_res = '0;
    case (r_aluop)
      EXE_MFHI_OP:              w_move_res = w_hi_fwd;
      EXE_MFLO_OP:              w_move_res = w_lo_fwd;
      EXE_MOVN_OP, EXE_MOVZ_OP: w_move_res = r_reg1;
      default:                  w_move_res = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // GPR result
  // ---------------------------------------------------------------------------
  always_comb begin
    ex_wdata_o = '0;
    case (r_alusel)
      EXE_RES_LOGIC: ex_wdata_o = w_logic_res;
      EXE_RES_SHIFT: ex_wdata_o = w_shift_res;
      EXE_RES_MOVE:  ex_wdata_o = w_move_res;
      default:       ex_wdata_o = '0;
    endcase
  end

  assign ex_wd_o = r_wd;

  always_comb begin
    ex_wreg_o = r_wreg;
`ifdef EX_MOVCOND_EN
    // rt was fully forwarded before capture, so testing it here is exact.
    if (r_aluop == ALUOP_W'(EXE_MOVN_OP)) begin
      ex_wreg_o = r_wreg & (r_reg2 != '0);
    end else if (r_aluop == ALUOP_W'(EXE_MOVZ_OP)) begin
      ex_wreg_o = r_wreg & (r_reg2 == '0);
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // HI/LO write: the untouched half is written back with its forwarded value
  // so HI and LO always update as a pair.
  // ---------------------------------------------------------------------------
  always_comb begin
    ex_whilo_o = WRITE_DISABLE;
    ex_hi_o    = '0;
    ex_lo_o    = '0;
    case (r_aluop)
      EXE_MTHI_OP: begin
        ex_whilo_o = WRITE_ENABLE;
        ex_hi_o    = r_reg1;
        ex_lo_o    = w_lo_fwd;
      end
      EXE_MTLO_OP: begin
        ex_whilo_o = WRITE_ENABLE;
        ex_hi_o    = w_hi_fwd;
        ex_lo_o    = r_reg1;
      end
      default: begin
        ex_whilo_o = WRITE_DISABLE;
        ex_hi_o    = '0;
        ex_lo_o    = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: reset, logic/shift/move results, HI/LO
// forwarding priority, stall/flush, MOVN/MOVZ gating and reset during stall.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, flush_i;
  logic [7:0]  id_aluop_i;
  logic [2:0]  id_alusel_i;
  logic [31:0] id_reg1_i, id_reg2_i;
  logic [4:0]  id_wd_i;
  logic        id_wreg_i;
  logic [31:0] hi_i, lo_i;
  logic        mem_whilo_i;
  logic [31:0] mem_hi_i, mem_lo_i;
  logic        wb_whilo_i;
  logic [31:0] wb_hi_i, wb_lo_i;
  logic        ex_wreg_o;
  logic [4:0]  ex_wd_o;
  logic [31:0] ex_wdata_o;
  logic        ex_whilo_o;
  logic [31:0] ex_hi_o, ex_lo_o;

  int n_vec = 0;
  int n_err = 0;

  ex_stage dut (
    .clk         (clk),
    .rst         (rst),
    .stall_i     (stall_i),
    .flush_i     (flush_i),
    .id_aluop_i  (id_aluop_i),
    .id_alusel_i (id_alusel_i),
    .id_reg1_i   (id_reg1_i),
    .id_reg2_i   (id_reg2_i),
    .id_wd_i     (id_wd_i),
    .id_wreg_i   (id_wreg_i),
    .hi_i        (hi_i),
    .lo_i        (lo_i),
    .mem_whilo_i (mem_whilo_i),
    .mem_hi_i    (mem_hi_i),
    .mem_lo_i    (mem_lo_i),
    .wb_whilo_i  (wb_whilo_i),
    .wb_hi_i     (wb_hi_i),
    .wb_lo_i     (wb_lo_i),
    .ex_wreg_o   (ex_wreg_o),
    .ex_wd_o     (ex_wd_o),
    .ex_wdata_o  (ex_wdata_o),
    .ex_whilo_o  (ex_whilo_o),
    .ex_hi_o     (ex_hi_o),
    .ex_lo_o     (ex_lo_o)
  );

  always #5 clk = ~clk;

  // Inputs change 1 ns after the edge and outputs are checked there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic [7:0] op, input logic [2:0] sel,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input logic [4:0] wd, input logic we);
    id_aluop_i  = op;
    id_alusel_i = sel;
    id_reg1_i   = r1;
    id_reg2_i   = r2;
    id_wd_i     = wd;
    id_wreg_i   = we;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic exp_movz_nz;
    rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
    hi_i = '0; lo_i = '0;
    mem_whilo_i = 1'b0; mem_hi_i = '0; mem_lo_i = '0;
    wb_whilo_i  = 1'b0; wb_hi_i  = '0; wb_lo_i  = '0;
    apply(EXE_OR_OP, EXE_RES_LOGIC, 32'h0F0F_0000, 32'h0000_00FF, 5'd5, 1'b1);

    // Reset for two cycles with an OR bundle waiting at decode
    tick(); tick();
    chk("rst_wreg",  32'(ex_wreg_o),  32'd0);
    chk("rst_wdata", ex_wdata_o,      32'd0);
    chk("rst_wd",    32'(ex_wd_o),    32'd0);
    chk("rst_whilo", 32'(ex_whilo_o), 32'd0);
    chk("rst_hi",    ex_hi_o,         32'd0);

    rst = 1'b0;
    tick();
    chk("or_wdata", ex_wdata_o,   32'h0F0F_00FF);
    chk("or_wd",    32'(ex_wd_o), 32'd5);
    chk("or_wreg",  32'(ex_wreg_o), 32'd1);

    // Other logic ops
    apply(EXE_NOR_OP, EXE_RES_LOGIC, 32'hF0F0_F0F0, 32'h0F0F_0000, 5'd6, 1'b1);
    tick();
    chk("nor_wdata", ex_wdata_o, 32'h0000_0F0F);
    apply(EXE_ANDI_OP, EXE_RES_LOGIC, 32'h1234_5678, 32'h0000_FFFF, 5'd7, 1'b1);
    tick();
    chk("andi_wdata", ex_wdata_o, 32'h0000_5678);

    // Shifts
    apply(EXE_SRA_OP, EXE_RES_SHIFT, 32'd4, 32'h8000_0010, 5'd8, 1'b1);
    tick();
    chk("sra_wdata", ex_wdata_o, 32'hF800_0001);
    apply(EXE_SRL_OP, EXE_RES_SHIFT, 32'd4, 32'h8000_0010, 5'd8, 1'b1);
    tick();
    chk("srl_wdata", ex_wdata_o, 32'h0800_0001);
    apply(EXE_SLLV_OP, EXE_RES_SHIFT, 32'h0000_0021, 32'h0000_0001, 5'd8, 1'b1);
    tick();
    chk("sllv_wdata", ex_wdata_o, 32'h0000_0002);
    apply(EXE_SRAV_OP, EXE_RES_SHIFT, 32'd0, 32'h8765_4321, 5'd8, 1'b1);
    tick();
    chk("srav0_wdata", ex_wdata_o, 32'h8765_4321);

    // Unknown alusel gives zero data
    apply(EXE_OR_OP, 3'b111, 32'hFFFF_FFFF, 32'h1, 5'd9, 1'b1);
    tick();
    chk("badsel_wdata", ex_wdata_o, 32'd0);

    // HI/LO forwarding priority
    hi_i = 32'h11; lo_i = 32'h44;
    wb_whilo_i  = 1'b1; wb_hi_i  = 32'h22; wb_lo_i  = 32'h55;
    mem_whilo_i = 1'b1; mem_hi_i = 32'h33; mem_lo_i = 32'h66;
    apply(EXE_MFHI_OP, EXE_RES_MOVE, 32'd0, 32'd0, 5'd10, 1'b1);
    tick();
    chk("mfhi_mem",   ex_wdata_o,      32'h33);
    chk("mfhi_whilo", 32'(ex_whilo_o), 32'd0);
    mem_whilo_i = 1'b0;
    #1;
    chk("mfhi_wb", ex_wdata_o, 32'h22);
    wb_whilo_i = 1'b0;
    #1;
    chk("mfhi_arch", ex_wdata_o, 32'h11);
    wb_whilo_i = 1'b1;
    apply(EXE_MFLO_OP, EXE_RES_MOVE, 32'd0, 32'd0, 5'd10, 1'b1);
    tick();
    chk("mflo_wb", ex_wdata_o, 32'h55);

    apply(EXE_MTLO_OP, EXE_RES_NOP, 32'h0000_ABCD, 32'd0, 5'd0, 1'b0);
    tick();
    chk("mtlo_whilo", 32'(ex_whilo_o), 32'd1);
    chk("mtlo_lo",    ex_lo_o,         32'h0000_ABCD);
    chk("mtlo_hi",    ex_hi_o,         32'h22);
    chk("mtlo_wreg",  32'(ex_wreg_o),  32'd0);
    mem_whilo_i = 1'b1;
    apply(EXE_MTHI_OP, EXE_RES_NOP, 32'h77, 32'd0, 5'd0, 1'b0);
    tick();
    chk("mthi_hi", ex_hi_o, 32'h77);
    chk("mthi_lo", ex_lo_o, 32'h66);
    mem_whilo_i = 1'b0; wb_whilo_i = 1'b0;

    // Stall holds the captured XOR while decode inputs change
    apply(EXE_XOR_OP, EXE_RES_LOGIC, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd9, 1'b1);
    tick();
    chk("xor_wdata", ex_wdata_o, 32'hF0F0_F0F0);
    stall_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      apply(EXE_AND_OP, EXE_RES_LOGIC, 32'(k + 1), 32'hFFFF_FFFF, 5'(k + 20), 1'b0);
      tick();
      chk("stall_wdata", ex_wdata_o,     32'hF0F0_F0F0);
      chk("stall_wd",    32'(ex_wd_o),   32'd9);
      chk("stall_wreg",  32'(ex_wreg_o), 32'd1);
    end

    // Stall and flush together: bubble
    flush_i = 1'b1;
    tick();
    chk("flush_wreg",  32'(ex_wreg_o), 32'd0);
    chk("flush_wdata", ex_wdata_o,     32'd0);
    flush_i = 1'b0; stall_i = 1'b0;

    // MOVZ / MOVN
`ifdef EX_MOVCOND_EN
    exp_movz_nz = 1'b0;
`else
    exp_movz_nz = 1'b1;
`endif
    apply(EXE_MOVZ_OP, EXE_RES_MOVE, 32'h55, 32'd0, 5'd11, 1'b1);
    tick();
    chk("movz0_wreg",  32'(ex_wreg_o), 32'd1);
    chk("movz0_wdata", ex_wdata_o,     32'h55);
    apply(EXE_MOVZ_OP, EXE_RES_MOVE, 32'h55, 32'd7, 5'd11, 1'b1);
    tick();
    chk("movz7_wreg",  32'(ex_wreg_o), 32'(exp_movz_nz));
    chk("movz7_wdata", ex_wdata_o,     32'h55);
    apply(EXE_MOVN_OP, EXE_RES_MOVE, 32'h55, 32'd7, 5'd11, 1'b1);
    tick();
    chk("movn7_wreg", 32'(ex_wreg_o), 32'd1);

    // Reset while stalled
    apply(EXE_AND_OP, EXE_RES_LOGIC, 32'h0000_F0F0, 32'h0000_FF00, 5'd3, 1'b1);
    tick();
    chk("and_wdata", ex_wdata_o, 32'h0000_F000);
    stall_i = 1'b1; rst = 1'b1;
    apply(EXE_ORI_OP, EXE_RES_LOGIC, 32'h1, 32'h2, 5'd4, 1'b1);
    tick();
    chk("rststall_wdata", ex_wdata_o,      32'd0);
    chk("rststall_wreg",  32'(ex_wreg_o),  32'd0);
    chk("rststall_wd",    32'(ex_wd_o),    32'd0);
    chk("rststall_whilo", 32'(ex_whilo_o), 32'd0);
    rst = 1'b0; stall_i = 1'b0;
    tick();
    chk("post_wdata", ex_wdata_o,     32'h3);
    chk("post_wd",    32'(ex_wd_o),   32'd4);
    chk("post_wreg",  32'(ex_wreg_o), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
